// File: rtl/mpadder_seq.sv
// mpadder_seq: sequences the carry-save mpadder through one Montgomery
// multiplication. It runs NBITS add-A / add-M / shift iterations, then a
// five-chunk carry-resolve pass, then repeated modulus-subtract passes.
// Subtraction stops when the adder reports completion, or when MAX_SUB
// passes have run without completion, in which case err is raised.
module mpadder_seq #(
  parameter int NBITS   = 512,
  parameter int MAX_SUB = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       b_bit,
  input  logic       c_zero,
  input  logic       sub_done,
  output logic [8:0] b_idx,
  output logic [1:0] a_sel,
  output logic       enable_c,
  output logic       shift,
  output logic       subtract,
  output logic [3:0] chunk_sel,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDA, S_ADDM, S_SHFT, S_RES, S_SUB, S_FIN
  } state_t;

  // The pass counter must be able to hold MAX_SUB itself.
  localparam int              PASS_W    = $clog2(MAX_SUB + 1);
  localparam logic [8:0]      LAST_IDX  = 9'(NBITS - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(MAX_SUB - 1);

  // Operand-mux encodings seen by the adder.
  localparam logic [1:0] SEL_ZERO  = 2'd0;
  localparam logic [1:0] SEL_A     = 2'd1;
  localparam logic [1:0] SEL_M     = 2'd2;
  localparam logic [1:0] SEL_NEG_M = 2'd3;

  // With bit 3 set, the adder's inter-chunk carry register is frozen.
  localparam logic [3:0] CHUNK_IDLE = 4'd8;

  state_t              state, state_nxt;
  logic [2:0]          chunk;
  logic [PASS_W-1:0]   pass;
  logic                err_q;

  logic last_bit;
  logic chunk_end;
  logic sub_term;

  assign last_bit  = (b_idx == LAST_IDX);
  assign chunk_end = (chunk == 3'd4);
  // A subtract pass ends the operation when the adder reports completion,
  // or when this was the last allowed pass.
  assign sub_term  = chunk_end && (sub_done || (pass == LAST_PASS));
  assign err       = err_q;

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments, so every
  // flop samples the pre-edge values of all other flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and output decode from the registered state and counters.
  // NOTE: every output gets a default before the case statement, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    a_sel     = SEL_ZERO;
    enable_c  = 1'b0;
    shift     = 1'b0;
    subtract  = 1'b0;
    chunk_sel = CHUNK_IDLE;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_ADDA;
      end
      S_ADDA: begin
        a_sel     = SEL_A;
        enable_c  = b_bit;
        state_nxt = S_ADDM;
      end
      S_ADDM: begin
        // c_zero already reflects the C registers written in ADDA.
        a_sel     = SEL_M;
        enable_c  = c_zero;
        state_nxt = S_SHFT;
      end
      S_SHFT: begin
        shift     = 1'b1;
        state_nxt = last_bit ? S_RES : S_ADDA;
      end
      S_RES: begin
        chunk_sel = {1'b0, chunk};
        if (chunk_end) state_nxt = S_SUB;
      end
      S_SUB: begin
        subtract  = 1'b1;
        a_sel     = SEL_NEG_M;
        chunk_sel = {1'b0, chunk};
        if (sub_term) state_nxt = S_FIN;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Bit index, chunk counter, pass counter and the sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_idx <= '0;
      chunk <= '0;
      pass  <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            b_idx <= '0;
            chunk <= '0;
            pass  <= '0;
            err_q <= 1'b0;
          end
        end
        S_SHFT: begin
          chunk <= '0;
          if (!last_bit) b_idx <= b_idx + 9'd1;
        end
        S_RES: begin
          chunk <= chunk_end ? 3'd0 : chunk + 3'd1;
        end
        S_SUB: begin
          if (chunk_end) begin
            chunk <= '0;
            if (!sub_done) begin
              pass <= pass + 1'b1;
              if (pass == LAST_PASS) err_q <= 1'b1;
            end
          end else begin
            chunk <= chunk + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mpadder_seq.sv
// Bench for mpadder_seq with NBITS=4, MAX_SUB=4. A cycle-indexed model
// derives every output from "cycles since start" arithmetic and is compared
// against the DUT on every falling edge. Directed runs record per-cycle
// traces that are checked against hand-computed literal expectations.
module tb_mpadder_seq;

  localparam int N     = 4;
  localparam int MS    = 4;
  localparam int T_RES = 3 * N + 1;
  localparam int T_SUB = 3 * N + 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       b_bit;
  logic       c_zero;
  logic       sub_done;
  logic [8:0] b_idx;
  logic [1:0] a_sel;
  logic       enable_c;
  logic       shift;
  logic       subtract;
  logic [3:0] chunk_sel;
  logic       busy;
  logic       done;
  logic       err;

  int n_cmp  = 0;
  int n_fail = 0;

  mpadder_seq #(.NBITS(N), .MAX_SUB(MS)) dut (
    .clk(clk), .reset(reset), .start(start), .b_bit(b_bit), .c_zero(c_zero),
    .sub_done(sub_done), .b_idx(b_idx), .a_sel(a_sel), .enable_c(enable_c),
    .shift(shift), .subtract(subtract), .chunk_sel(chunk_sel), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 'h%0h, expected 'h%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_active, m_fin, m_err;
  int m_t, m_bidx;

  // Model update: cycle index advances while busy; the chunk-4 cycles of the
  // subtract phase decide between another pass and completion.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0; m_fin <= 1'b0; m_err <= 1'b0; m_t <= 0; m_bidx <= 0;
    end else if (m_fin) begin
      m_fin <= 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1; m_t <= 1; m_err <= 1'b0; m_bidx <= 0;
      end
    end else begin
      if (m_t <= 3 * N) m_bidx <= (m_t - 1) / 3;
      if (m_t >= T_SUB && (m_t - T_SUB) % 5 == 4) begin
        if (sub_done) begin
          m_active <= 1'b0; m_fin <= 1'b1;
        end else if ((m_t - T_SUB) / 5 + 1 >= MS) begin
          m_err <= 1'b1; m_active <= 1'b0; m_fin <= 1'b1;
        end else begin
          m_t <= m_t + 1;
        end
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  // Compare process: every output against the model on every falling edge.
  always @(negedge clk) begin
    int e_asel, e_chunk, e_bidx;
    bit e_en, e_sh, e_sub, e_busy, e_done;
    e_asel = 0; e_en = 1'b0; e_sh = 1'b0; e_sub = 1'b0; e_chunk = 8;
    e_busy = 1'b0; e_done = 1'b0; e_bidx = m_bidx;
    if (m_fin) begin
      e_busy = 1'b1; e_done = 1'b1;
    end else if (m_active) begin
      e_busy = 1'b1;
      if (m_t <= 3 * N) begin
        e_bidx = (m_t - 1) / 3;
        case ((m_t - 1) % 3)
          0: begin e_asel = 1; e_en = b_bit; end
          1: begin e_asel = 2; e_en = c_zero; end
          default: e_sh = 1'b1;
        endcase
      end else if (m_t < T_SUB) begin
        e_chunk = m_t - T_RES;
      end else begin
        e_sub = 1'b1; e_asel = 3; e_chunk = (m_t - T_SUB) % 5;
      end
    end
    check("cyc.a_sel",     64'(a_sel),     64'(e_asel));
    check("cyc.enable_c",  64'(enable_c),  64'(e_en));
    check("cyc.shift",     64'(shift),     64'(e_sh));
    check("cyc.subtract",  64'(subtract),  64'(e_sub));
    check("cyc.chunk_sel", 64'(chunk_sel), 64'(e_chunk));
    check("cyc.busy",      64'(busy),      64'(e_busy));
    check("cyc.done",      64'(done),      64'(e_done));
    check("cyc.err",       64'(err),       64'(m_err));
    check("cyc.b_idx",     64'(b_idx),     64'(e_bidx));
  end

  // ---------------- directed runs with traces ----------------
  logic [63:0] en_m, sh_m, sub_m, done_m, busy_m;
  int chunk_tr[64], bidx_tr[64], asel_tr[64], err_tr[64];

  // Pulse start in cycle 0, then record cycles 1..ncyc. start is re-pulsed
  // in cycles st1/st2 (0 = none) to exercise the ignore rules.
  task automatic run_op(input int ncyc, input bit b, input bit c, input bit s,
                        input int st1, input int st2);
    b_bit = b; c_zero = c; sub_done = s;
    en_m = '0; sh_m = '0; sub_m = '0; done_m = '0; busy_m = '0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      start = (n == st1) || (n == st2);
      @(negedge clk);
      en_m[n] = enable_c; sh_m[n] = shift; sub_m[n] = subtract;
      done_m[n] = done; busy_m[n] = busy;
      chunk_tr[n] = int'(chunk_sel); bidx_tr[n] = int'(b_idx);
      asel_tr[n] = int'(a_sel); err_tr[n] = int'(err);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; b_bit = 1'b0; c_zero = 1'b0; sub_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset.chunk_sel", 64'(chunk_sel), 64'd8);
    check("reset.busy",      64'(busy),      64'd0);

    // Iteration pattern, all-ones operand, one subtract pass.
    run_op(25, 1'b1, 1'b1, 1'b1, 0, 0);
    check("ones.enable_mask", en_m,   64'h0000_0000_0000_0DB6);
    check("ones.shift_mask",  sh_m,   64'h0000_0000_0000_1248);
    check("ones.sub_mask",    sub_m,  64'h0000_0000_007C_0000);
    check("ones.done_mask",   done_m, 64'h0000_0000_0080_0000);
    check("ones.busy_mask",   busy_m, 64'h0000_0000_00FF_FFFE);
    for (int k = 0; k < N; k++) check("ones.b_idx", 64'(bidx_tr[3 * k + 1]), 64'(k));
    check("ones.sub_asel",    64'(asel_tr[18]), 64'd3);
    check("ones.fin_err",     64'(err_tr[23]),  64'd0);
    check("ones.idle_chunk",  64'(chunk_tr[24]), 64'd8);

    // Zero operand: no loads, four shifts, resolve chunks 0..4.
    run_op(25, 1'b0, 1'b0, 1'b1, 0, 0);
    check("zero.enable_mask", en_m, 64'h0);
    check("zero.shift_mask",  sh_m, 64'h0000_0000_0000_1248);
    check("zero.sub_mask",    sub_m, 64'h0000_0000_007C_0000);
    for (int i = 0; i < 5; i++) check("zero.res_chunk", 64'(chunk_tr[13 + i]), 64'(i));

    // start pulses in an ADD cycle and in FIN are both ignored.
    run_op(25, 1'b1, 1'b0, 1'b1, 5, 23);
    check("ign.done_mask",  done_m, 64'h0000_0000_0080_0000);
    check("ign.done_count", 64'($countones(done_m)), 64'd1);
    check("ign.busy_mask",  busy_m, 64'h0000_0000_00FF_FFFE);
    check("ign.shift_mask", sh_m,   64'h0000_0000_0000_1248);

    // Overflow: sub_done never arrives, four passes then err.
    run_op(42, 1'b1, 1'b0, 1'b0, 0, 0);
    check("ovf.done_mask",  done_m, 64'h0000_0040_0000_0000);
    check("ovf.sub_mask",   sub_m,  64'h0000_003F_FFFC_0000);
    check("ovf.busy_mask",  busy_m, 64'h0000_007F_FFFF_FFFE);
    check("ovf.chunk_22",   64'(chunk_tr[22]), 64'd4);
    check("ovf.chunk_wrap", 64'(chunk_tr[23]), 64'd0);
    check("ovf.chunk_37",   64'(chunk_tr[37]), 64'd4);
    check("ovf.err_pre",    64'(err_tr[37]), 64'd0);
    check("ovf.err_fin",    64'(err_tr[38]), 64'd1);
    check("ovf.err_sticky", 64'(err_tr[42]), 64'd1);

    // Reset mid-SUB at chunk 2; the start that begins this run clears err.
    run_op(19, 1'b0, 1'b0, 1'b0, 0, 0);
    check("rst.err_cleared", 64'(err_tr[1]), 64'd0);
    #1;
    check("rst.pre_chunk", 64'(chunk_sel), 64'd2);
    check("rst.pre_sub",   64'(subtract),  64'd1);
    reset = 1'b1;
    #1;
    check("rst.chunk_sel", 64'(chunk_sel), 64'd8);
    check("rst.busy",      64'(busy),      64'd0);
    check("rst.done",      64'(done),      64'd0);
    check("rst.subtract",  64'(subtract),  64'd0);
    check("rst.a_sel",     64'(a_sel),     64'd0);
    check("rst.b_idx",     64'(b_idx),     64'd0);
    check("rst.enable_c",  64'(enable_c),  64'd0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;
    run_op(3, 1'b1, 1'b1, 1'b1, 0, 0);
    check("rst.restart_bidx", 64'(bidx_tr[1]), 64'd0);
    check("rst.restart_asel", 64'(asel_tr[1]), 64'd1);
    check("rst.restart_busy", 64'(busy_m[1]),  64'd1);
    repeat (30) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
